// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Core-to-data-memory load/store sequencer with byte lanes,
//               misaligned split accesses and load sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_WORDS = 121
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [31:0] c_mem_words = MEM_WORDS;

    state_t      r_state;
    state_t      w_state_nxt;

    // Captured request
    logic        r_we;
    logic [1:0]  r_size;
    logic        r_uns;
    logic [1:0]  r_off;
    logic [29:0] r_w0;
    logic [31:0] r_wdata;
    logic [7:0]  r_mask;
    logic        r_err;
    logic [31:0] r_lowbuf;

    // Registered memory-side and response outputs
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic [3:0]  r_mem_we;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic [1:0]  w_off;
    logic [7:0]  w_base;
    logic [7:0]  w_mask;
    logic [29:0] w_w0;
    logic [30:0] w_w1;
    logic        w_err;
    logic [31:0] w_din0;
    logic [31:0] w_din1;
    logic [4:0]  w_lo_amt;
    logic [5:0]  w_hi_amt;
    logic [31:0] w_aligned;
    logic [31:0] w_ext;
    logic [31:0] w_rdata_fin;
    logic [31:0] w_mem_addr_nxt;
    logic [31:0] w_mem_din_nxt;
    logic [3:0]  w_mem_we_nxt;

    assign req_ready  = (r_state == S_IDLE);
    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;
    assign mem_addr   = r_mem_addr;
    assign mem_din    = r_mem_din;
    // A store pending in ACC0/ACC1 must not land on the reset edge
    assign mem_we     = rst ? 4'b0000 : r_mem_we;

    // Lane mask and range check on the incoming request
    always_comb begin
        w_base = 8'h0F;
        case (req_size)
            2'b00:   w_base = 8'h01;
            2'b01:   w_base = 8'h03;
            default: w_base = 8'h0F;
        endcase
    end

    assign w_off  = req_addr[1:0];
    assign w_mask = w_base << w_off;
    assign w_w0   = req_addr[31:2];
    assign w_w1   = {1'b0, w_w0} + 31'd1;
    assign w_err  = (req_size == 2'b11)
                 || ({2'b00, w_w0} >= c_mem_words)
                 || ((|w_mask[7:4]) && ({1'b0, w_w1} >= c_mem_words));
    assign w_din0 = req_wdata << {w_off, 3'b000};

    // A split access always has a nonzero offset, so w_hi_amt stays in 8..24
    assign w_lo_amt = {r_off, 3'b000};
    assign w_hi_amt = 6'd32 - {1'b0, r_off, 3'b000};
    assign w_din1   = r_wdata >> w_hi_amt;

    always_comb begin
        w_aligned = mem_dout >> w_lo_amt;
        if (|r_mask[7:4]) begin
            w_aligned = (mem_dout << w_hi_amt) | (r_lowbuf >> w_lo_amt);
        end
    end

    always_comb begin
        w_ext = w_aligned;
        case (r_size)
            2'b00:   w_ext = r_uns ? {24'b0, w_aligned[7:0]}
                                   : {{24{w_aligned[7]}}, w_aligned[7:0]};
            2'b01:   w_ext = r_uns ? {16'b0, w_aligned[15:0]}
                                   : {{16{w_aligned[15]}}, w_aligned[15:0]};
            default: w_ext = w_aligned;
        endcase
    end

    assign w_rdata_fin = (r_err || r_we) ? 32'b0 : w_ext;

    // Next state and next memory-side drive
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_addr_nxt = r_mem_addr;
        w_mem_din_nxt  = r_mem_din;
        w_mem_we_nxt   = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = S_ACC0;
                    w_mem_addr_nxt = {w_w0, 2'b00};
                    w_mem_din_nxt  = w_din0;
                    w_mem_we_nxt   = (req_we && !w_err) ? w_mask[3:0] : 4'b0000;
                end
            end
            S_ACC0: begin
                if (|r_mask[7:4]) begin
                    w_state_nxt    = S_ACC1;
                    w_mem_addr_nxt = {r_w0 + 30'd1, 2'b00};
                    w_mem_din_nxt  = w_din1;
                    w_mem_we_nxt   = (r_we && !r_err) ? r_mask[7:4] : 4'b0000;
                end else begin
                    w_state_nxt = S_FIN;
                end
            end
            S_ACC1: w_state_nxt = S_FIN;
            S_FIN:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_mem_addr   <= 32'b0;
            r_mem_din    <= 32'b0;
            r_mem_we     <= 4'b0000;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'b0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_din    <= w_mem_din_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_resp_valid <= (r_state == S_FIN);
            if (r_state == S_FIN) begin
                r_resp_rdata <= w_rdata_fin;
                r_resp_err   <= r_err;
            end
        end
    end

    // Request capture and first-word buffer need no reset
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_off   <= w_off;
            r_w0    <= w_w0;
            r_wdata <= req_wdata;
            r_mask  <= w_mask;
            r_err   <= w_err;
        end
        if (r_state == S_ACC1) begin
            r_lowbuf <= mem_dout;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a word memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int MEM_WORDS = 121;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout = 32'b0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout)
    );

    always #5 clk = ~clk;

    // Data memory: synchronous read returning the pre-write value
    logic [31:0] mem [0:MEM_WORDS-1] = '{default: 32'h0000_0002};
    int midx;
    always @(posedge clk) begin
        midx = int'(mem_addr[31:2]);
        if (mem_addr[31:2] < 30'(MEM_WORDS)) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem[midx][8*b +: 8] <= mem_din[8*b +: 8];
            end
            mem_dout <= mem[midx];
        end else begin
            mem_dout <= 32'b0;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t  sb[$];
    string sb_name[$];

    int n_vec = 0;
    int n_err = 0;
    int n_resp = 0;
    int we_cnt = 0;
    int last_resp_cyc = 0;
    int prev_resp_cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: pop and compare on every resp_valid pulse
    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (|mem_we) we_cnt++;
        if (resp_valid) begin
            n_resp++;
            prev_resp_cyc = last_resp_cyc;
            last_resp_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_resp_depth", 32'(sb.size()), 32'd1);
            end else begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                check({nm, "_rdata"}, resp_rdata, e.rdata);
                check({nm, "_err"}, {31'b0, resp_err}, {31'b0, e.err});
                if (e.lat >= 0) check({nm, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                         input bit expect_resp, input bit drop);
        int guard = 0;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check({name, "_ready"}, {31'b0, req_ready}, 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (expect_resp) begin
            sb.push_back('{rdata: exp_rdata, err: exp_err, lat: lat, acc: cyc});
            sb_name.push_back(name);
        end
        @(negedge clk);
        if (drop) req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (sb.size() != 0 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("drain_depth", 32'(sb.size()), 32'd0);
        sb.delete();
        sb_name.delete();
        @(negedge clk);
    endtask

    initial begin
        int w0;
        int r0;
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int r0;
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", {31'b0, resp_err}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_din", mem_din, 32'd0);
        check("rst_mem_we", {28'b0, mem_we}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'b0, req_ready}, 32'd1);

        // Aligned word load, ready low while busy
        issue("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0002, 1'b0, 3, 1'b1, 1'b1);
        check("ready_acc0", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
        check("ready_fin", {31'b0, req_ready}, 32'd0);
        wait_done();

        // Byte/half extraction and extension
        issue("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("lb21", 1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("lb23", 1'b0, 2'b00, 1'b0, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("lbu23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("lh22", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 3, 1'b1, 1'b1);
        wait_done();

        // Misaligned split store, then loads across the boundary
        issue("sw41", 1'b1, 2'b10, 1'b0, 32'h41, 32'hAABB_CCDD, 32'h0, 1'b0, 4, 1'b1, 1'b1);
        check("sw41_acc0_addr", mem_addr, 32'h40);
        check("sw41_acc0_we", {28'b0, mem_we}, 32'b1110);
        check("sw41_acc0_din", mem_din, 32'hBBCC_DD00);
        @(negedge clk);
        check("sw41_acc1_addr", mem_addr, 32'h44);
        check("sw41_acc1_we", {28'b0, mem_we}, 32'b0001);
        check("sw41_acc1_din", mem_din, 32'h0000_00AA);
        wait_done();
        issue("lw41", 1'b0, 2'b10, 1'b0, 32'h41, 32'h0, 32'hAABB_CCDD, 1'b0, 4, 1'b1, 1'b1);
        wait_done();
        issue("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hBBCC_DD02, 1'b0, 3, 1'b1, 1'b1);
        wait_done();

        // Top of memory and error cases
        issue("sh1e2", 1'b1, 2'b01, 1'b0, 32'h1E2, 32'h0000_1234, 32'h0, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("lw1e0", 1'b0, 2'b10, 1'b0, 32'h1E0, 32'h0, 32'h1234_0002, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        w0 = we_cnt;
        issue("sw1e1", 1'b1, 2'b10, 1'b0, 32'h1E1, 32'hCAFE_F00D, 32'h0, 1'b1, 4, 1'b1, 1'b1);
        wait_done();
        check("sw1e1_we_cycles", 32'(we_cnt - w0), 32'd0);
        check("word120_model", mem[120], 32'h1234_0002);
        issue("lw1e0_again", 1'b0, 2'b10, 1'b0, 32'h1E0, 32'h0, 32'h1234_0002, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        issue("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, -1, 1'b1, 1'b1);
        wait_done();
        issue("lw1e4", 1'b0, 2'b10, 1'b0, 32'h1E4, 32'h0, 32'h0, 1'b1, 3, 1'b1, 1'b1);
        wait_done();

        // Reset during ACC0 of a store
        issue("sw30_abort", 1'b1, 2'b10, 1'b0, 32'h30, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 1'b0, 1'b1);
        check("sw30_acc0_we", {28'b0, mem_we}, 32'b1111);
        r0  = n_resp;
        rst = 1'b1;
        #1;
        check("sw30_rst_we", {28'b0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("sw30_no_resp", 32'(n_resp - r0), 32'd0);
        issue("lw30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0000_0002, 1'b0, 3, 1'b1, 1'b1);
        wait_done();

        // Back-to-back issue with req_valid held high
        issue("b2b_lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0000_0002, 1'b0, 3, 1'b1, 1'b0);
        issue("b2b_sw14", 1'b1, 2'b10, 1'b0, 32'h14, 32'h1111_2222, 32'h0, 1'b0, 3, 1'b1, 1'b1);
        wait_done();
        check("b2b_spacing", 32'(last_resp_cyc - prev_resp_cyc), 32'd3);
        issue("lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h1111_2222, 1'b0, 3, 1'b1, 1'b1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
